// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field-level descriptions into 32-bit words,
// tags each with a sequential word address and buffers it in a 2-entry FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       NOP  = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_I_LD   = 7'b0000011;
    localparam logic [6:0] OP_I_JALR = 7'b1100111;
    localparam logic [6:0] OP_I_SYS  = 7'b1110011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_U_LUI  = 7'b0110111;
    localparam logic [6:0] OP_U_AUI  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    fmt_t              fmt;
    logic [31:0]       enc_word;
    logic              enc_err;
    logic              range_bad;

    logic [1:0][31:0]       mem_instr;
    logic [1:0][ADDR_W-1:0] mem_addr;
    logic [1:0]             mem_err;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [ADDR_W-1:0]      next_addr;
    logic [ADDR_W-1:0]      tag_addr;
    logic                   push;
    logic                   pop;

    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            OP_R:                                    fmt = FMT_R;
            OP_I_ALU, OP_I_LD, OP_I_JALR, OP_I_SYS:  fmt = FMT_I;
            OP_S:                                    fmt = FMT_S;
            OP_B:                                    fmt = FMT_B;
            OP_U_LUI, OP_U_AUI:                      fmt = FMT_U;
            OP_J:                                    fmt = FMT_J;
            default:                                 fmt = FMT_BAD;
        endcase
    end

    // Shift-immediates need no special case: funct7 already rides in imm[11:5].
    always_comb begin
        enc_word = NOP;
        case (fmt)
            FMT_R:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                                 imm[4:1], imm[11], opcode};
            FMT_U:   enc_word = {imm[31:12], rd, opcode};
            FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = NOP;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    logic sext11_ok;
    logic sext12_ok;
    logic sext20_ok;

    assign sext11_ok = (&imm[31:11]) || !(|imm[31:11]);
    assign sext12_ok = (&imm[31:12]) || !(|imm[31:12]);
    assign sext20_ok = (&imm[31:20]) || !(|imm[31:20]);

    // Flagged words are still encoded from the truncated immediate.
    always_comb begin
        range_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_bad = !sext11_ok;
            FMT_B:        range_bad = !sext12_ok || imm[0];
            FMT_J:        range_bad = !sext20_ok || imm[0];
            FMT_U:        range_bad = |imm[11:0];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign enc_err = (fmt == FMT_BAD) || range_bad;

    assign in_ready  = (count != 2'd2) && rst_n;
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A clear coinciding with an accept numbers that word from the base.
    assign tag_addr = addr_clr ? BASE : next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_instr <= '0;
            mem_addr  <= '0;
            mem_err   <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            next_addr <= BASE;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc_word;
                mem_addr[wr_ptr]  <= tag_addr;
                mem_err[wr_ptr]   <= enc_err;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (push) begin
                next_addr <= tag_addr + ADDR_W'(1);
            end else if (addr_clr) begin
                next_addr <= BASE;
            end
        end
    end

    // Empty FIFO presents zeros rather than stale entries.
    assign out_instr = out_valid ? mem_instr[rd_ptr] : 32'h0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;
    assign out_err   = out_valid ? mem_err[rd_ptr]   : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: known-answer vectors, hand-built corner sequences
// and a random stream checked against a queue-based reference model.
module tb_instr_encoder;

    localparam int unsigned BASE_A = 3;
    localparam int unsigned BASE_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        addr_clr;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        in_ready_b, out_valid_b, out_err_b;
    logic [31:0] out_instr_b;
    logic [1:0]  out_addr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(BASE_A)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .addr_clr(addr_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(BASE_B)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .addr_clr(addr_clr), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_instr(out_instr_b), .out_addr(out_addr_b),
        .out_err(out_err_b)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int unsigned a;
        int unsigned b;
    } ent_t;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    ent_t        q[$];
    int unsigned na;
    int unsigned nb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate ranges expressed as signed value intervals.
    function automatic void model_enc(input logic [6:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] im,
                                      output logic [31:0] w, output logic e);
        int si;
        si = $signed(im);
        e  = 1'b0;
        case (op)
            7'b0110011: w = {f7, s2, s1, f3, d, op};
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                w = {im[11:0], s1, f3, d, op};
`ifdef ENC_RANGE_CHECK_EN
                e = (si < -2048) || (si > 2047);
`endif
            end
            7'b0100011: begin
                w = {im[11:5], s2, s1, f3, im[4:0], op};
`ifdef ENC_RANGE_CHECK_EN
                e = (si < -2048) || (si > 2047);
`endif
            end
            7'b1100011: begin
                w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
`ifdef ENC_RANGE_CHECK_EN
                e = (si < -4096) || (si > 4095) || (si % 2 != 0);
`endif
            end
            7'b0110111, 7'b0010111: begin
                w = {im[31:12], d, op};
`ifdef ENC_RANGE_CHECK_EN
                e = (im % 4096) != 0;
`endif
            end
            7'b1101111: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, op};
`ifdef ENC_RANGE_CHECK_EN
                e = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
`endif
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    task automatic check_all();
        logic        ev;
        logic [31:0] ei;
        logic        ee;
        int unsigned ea, eb;
        ev = (q.size() != 0);
        ei = ev ? q[0].instr : 32'h0;
        ee = ev ? q[0].err : 1'b0;
        ea = ev ? q[0].a : 0;
        eb = ev ? q[0].b : 0;
        chk("in_ready",    in_ready,    rst_n && (q.size() != 2));
        chk("out_valid",   out_valid,   ev);
        chk("out_instr",   out_instr,   ei);
        chk("out_err",     out_err,     ee);
        chk("out_addr",    out_addr,    ea);
        chk("w2_in_ready", in_ready_b,  rst_n && (q.size() != 2));
        chk("w2_valid",    out_valid_b, ev);
        chk("w2_instr",    out_instr_b, ei);
        chk("w2_err",      out_err_b,   ee);
        chk("w2_addr",     out_addr_b,  eb);
    endtask

    // One clock cycle: drive at negedge, model at posedge, compare at negedge.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic ordy, input logic clr);
        logic acc, pop;
        ent_t e;
        in_valid = v; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; out_ready = ordy; addr_clr = clr;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        e = '{32'h0, 1'b0, 0, 0};
        if (acc) begin
            model_enc(op, d, s1, s2, f3, f7, im, e.instr, e.err);
            e.a = clr ? BASE_A : na;
            e.b = clr ? BASE_B : nb;
        end
        @(posedge clk);
        if (pop) q.delete(0);
        if (acc) begin
            q.push_back(e);
            na = (e.a + 1) % 1024;
            nb = (e.b + 1) % 4;
        end else if (clr) begin
            na = BASE_A;
            nb = BASE_B;
        end
        @(negedge clk);
        in_valid = 1'b0;
        addr_clr = 1'b0;
        check_all();
    endtask

    task automatic push_addi(input logic [4:0] d, input logic ordy, input logic clr);
        step(1'b1, 7'b0010011, d, 5'd2, 5'd0, 3'd0, 7'd0, 32'(d) * 32'd5, ordy, clr);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, ordy, 1'b0);
    endtask

    // Called at a negedge; asserts reset mid-low-phase and releases at the next negedge.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        q.delete();
        na = BASE_A;
        nb = BASE_B;
        #1;
        chk("rst_out_valid", out_valid, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr",  out_addr,  32'h0);
        chk("rst_out_err",   out_err,   32'h0);
        chk("rst_in_ready",  in_ready,  32'h0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t        tv[11];
    logic [6:0]  ops[10];
    logic [6:0]  r_op;
    logic [31:0] r_imm;
    int unsigned r_sel;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; addr_clr = 1'b0; out_ready = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        na = BASE_A;
        nb = BASE_B;

        tv[0]  = '{7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
        tv[1]  = '{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463, 1'b0};
        tv[2]  = '{7'b0100011, 5'd0, 5'd3, 5'd5, 3'd2, 7'd0, 32'd12,        32'h0051_A623, 1'b0};
        tv[3]  = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0};
        tv[4]  = '{7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        tv[5]  = '{7'b0001111, 5'd3, 5'd4, 5'd5, 3'd1, 7'd9, 32'h0000_0123, 32'h0000_0013, 1'b1};
        tv[6]  = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,         32'h0020_81B3, 1'b0};
        tv[7]  = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h4020_81B3, 1'b0};
        tv[8]  = '{7'b0010011, 5'd5, 5'd6, 5'd0, 3'd5, 7'd0, 32'h0000_0403, 32'h4033_5293, 1'b0};
        tv[9]  = '{7'b0010111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h0000_1097, 1'b0};
`ifdef ENC_RANGE_CHECK_EN
        tv[10] = '{7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0013, 1'b1};
`else
        tv[10] = '{7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0013, 1'b0};
`endif
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer vectors; with out_ready high the head is always the latest word.
        for (int i = 0; i < 11; i++) begin
            step(1'b1, tv[i].op, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].f3, tv[i].f7,
                 tv[i].imm, 1'b1, 1'b0);
            chk("vec_instr", out_instr, tv[i].exp_instr);
            chk("vec_err",   out_err,   tv[i].exp_err);
        end
        idle(1'b1);

        // Backpressure: third word waits until a slot frees up.
        push_addi(5'd7, 1'b0, 1'b0);
        push_addi(5'd8, 1'b0, 1'b0);
        chk("bp_in_ready", in_ready, 32'h0);
        push_addi(5'd9, 1'b0, 1'b0);
        push_addi(5'd9, 1'b0, 1'b0);
        push_addi(5'd9, 1'b1, 1'b0);
        push_addi(5'd9, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Address wrap on the 2-bit instance.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            push_addi(5'(k + 1), 1'b1, 1'b0);
            chk("wrap_addr", out_addr_b, 32'(k % 4));
        end
        idle(1'b1);

        // Clear together with the third accept.
        apply_reset();
        push_addi(5'd1, 1'b1, 1'b0);
        push_addi(5'd2, 1'b1, 1'b0);
        push_addi(5'd3, 1'b1, 1'b1);
        chk("clr_addr_w2", out_addr_b, 32'd0);
        chk("clr_addr",    out_addr,   32'(BASE_A));
        push_addi(5'd4, 1'b1, 1'b0);
        chk("clr_next_w2", out_addr_b, 32'd1);
        chk("clr_next",    out_addr,   32'(BASE_A + 1));
        idle(1'b1);

        for (int n = 0; n < 3000; n++) begin
            r_sel = $urandom_range(0, 11);
            r_op  = (r_sel < 10) ? ops[r_sel] : 7'($urandom);
            case ($urandom_range(0, 3))
                0:       r_imm = $urandom;
                1:       r_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2:       r_imm = $urandom & 32'hFFFF_F000;
                default: r_imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
            endcase
            step($urandom_range(0, 3) != 0, r_op, 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 7'($urandom), r_imm, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 31) == 0);
        end
        idle(1'b1);
        idle(1'b1);

        // Reset with two words buffered.
        push_addi(5'd11, 1'b0, 1'b0);
        push_addi(5'd12, 1'b0, 1'b0);
        apply_reset();
        push_addi(5'd13, 1'b1, 1'b0);
        chk("post_rst_addr", out_addr, 32'(BASE_A));
        chk("post_rst_valid", out_valid, 32'h1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
